// File: rtl/pin_entry.sv
// pin_entry: keypad PIN assembly, submit/check window and per-session attempt lockout.
module pin_entry #(
   parameter int PASSWORD_WIDTH = 16,
   parameter int MAX_TRIES      = 3,
   parameter int CHECK_LAT      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      card_in,
   input  logic                      key_valid,
   input  logic [3:0]                key_code,
   input  logic                      wrong_psw,
   output logic [PASSWORD_WIDTH-1:0] password_input,
   output logic                      psw_submit,
   output logic [2:0]                digit_count,
   output logic [1:0]                tries_left,
   output logic                      accepted,
   output logic                      card_locked,
   output logic                      key_err
);
   localparam int ND = PASSWORD_WIDTH / 4;
   localparam int CW = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;
   typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_ACC, S_LOCK} state_t;
   state_t                    r_state;
   logic [PASSWORD_WIDTH-1:0] r_buf;
   logic [PASSWORD_WIDTH-1:0] r_pw;
   logic [2:0]                r_cnt;
   logic [1:0]                r_tries;
   logic [CW-1:0]             r_win;
   logic                      r_submit;
   logic                      r_acc;
   logic                      r_lock;
   logic                      r_kerr;
   always_ff @(posedge clk) begin
      if (rst || !card_in) begin
         r_state  <= S_IDLE;
         r_buf    <= '0;
         r_pw     <= '0;
         r_cnt    <= '0;
         r_tries  <= '0;
         r_win    <= '0;
         r_submit <= 1'b0;
         r_acc    <= 1'b0;
         r_lock   <= 1'b0;
         r_kerr   <= 1'b0;
      end else begin
         r_submit <= 1'b0;
         r_kerr   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_state <= S_ENTRY;
               r_tries <= 2'(MAX_TRIES);
            end
            S_ENTRY: if (key_valid) begin
               if (key_code <= 4'd9) begin
                  if (r_cnt < 3'(ND)) begin
                     r_buf <= {r_buf[PASSWORD_WIDTH-5:0], key_code};
                     r_cnt <= r_cnt + 3'd1;
                  end else r_kerr <= 1'b1;
               end else if (key_code == 4'hA) begin
                  r_buf <= '0;
                  r_cnt <= '0;
               end else if (key_code == 4'hB) begin
                  if (r_cnt != 3'd0) begin
                     r_buf <= r_buf >> 4;
                     r_cnt <= r_cnt - 3'd1;
                  end else r_kerr <= 1'b1;
               end else if (key_code == 4'hE) begin
                  if (r_cnt == 3'(ND)) begin
                     r_pw     <= r_buf;
                     r_submit <= 1'b1;
                     r_win    <= '0;
                     r_state  <= S_CHECK;
                  end else r_kerr <= 1'b1;
               end else r_kerr <= 1'b1;
            end
            S_CHECK: begin
               r_kerr <= key_valid;
               // a mismatch on the last window cycle still beats expiry
               if (wrong_psw) begin
                  r_tries <= r_tries - 2'd1;
                  r_buf   <= '0;
                  r_cnt   <= '0;
                  r_pw    <= '0;
                  r_state <= (r_tries == 2'd1) ? S_LOCK : S_ENTRY;
                  r_lock  <= (r_tries == 2'd1);
               end else if (r_win == CW'(CHECK_LAT - 1)) begin
                  r_state <= S_ACC;
                  r_acc   <= 1'b1;
               end else r_win <= r_win + 1'b1;
            end
            default: r_kerr <= key_valid;
         endcase
      end
   end
   assign password_input = r_pw;
   assign psw_submit     = r_submit;
   assign digit_count    = r_cnt;
   assign tries_left     = r_tries;
   assign accepted       = r_acc;
   assign card_locked    = r_lock;
   assign key_err        = r_kerr;
endmodule

// File: tb/tb_pin_entry.sv
// tb_pin_entry: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_pin_entry;
   localparam int ND = 4;
   localparam int MAX_TRIES = 3;
   localparam int CHECK_LAT = 4;
   localparam int P_IDLE = 0, P_ENTRY = 1, P_CHECK = 2, P_ACC = 3, P_LOCK = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        card_in = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic        wrong_psw = 1'b0;
   logic [15:0] password_input;
   logic        psw_submit;
   logic [2:0]  digit_count;
   logic [1:0]  tries_left;
   logic        accepted;
   logic        card_locked;
   logic        key_err;
   int n_chk = 0;
   int n_pass = 0;
   int m_ph, m_pw, m_sub, m_tries, m_acc, m_lock, m_err, m_elapsed;
   int dq[$];
   typedef struct {
      bit rs, ci, kv; logic [3:0] kc; bit wp;
      int pw, sub, cnt, tries, acc, lock, err;
   } vec_t;
   vec_t vecs[$];
   pin_entry #(.PASSWORD_WIDTH(16), .MAX_TRIES(MAX_TRIES), .CHECK_LAT(CHECK_LAT)) dut (
      .clk(clk), .rst(rst), .card_in(card_in), .key_valid(key_valid), .key_code(key_code),
      .wrong_psw(wrong_psw), .password_input(password_input), .psw_submit(psw_submit),
      .digit_count(digit_count), .tries_left(tries_left), .accepted(accepted),
      .card_locked(card_locked), .key_err(key_err));
   always #5 clk = ~clk;
   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask
   function automatic int pin_value();
      int p = 0;
      foreach (dq[i]) p = p * 16 + dq[i];
      return p;
   endfunction
   task automatic model(bit rs, bit ci, bit kv, logic [3:0] kc, bit wp);
      if (rs || !ci) begin
         m_ph = P_IDLE; dq.delete(); m_pw = 0; m_sub = 0; m_tries = 0;
         m_acc = 0; m_lock = 0; m_err = 0; m_elapsed = 0;
         return;
      end
      m_sub = 0;
      m_err = 0;
      case (m_ph)
         P_IDLE: begin m_ph = P_ENTRY; m_tries = MAX_TRIES; end
         P_ENTRY: if (kv) begin
            if (kc < 10) begin
               if (dq.size() < ND) dq.push_back(int'(kc)); else m_err = 1;
            end else if (kc == 4'hA) dq.delete();
            else if (kc == 4'hB) begin
               if (dq.size() > 0) void'(dq.pop_back()); else m_err = 1;
            end else if (kc == 4'hE) begin
               if (dq.size() == ND) begin
                  m_pw = pin_value(); m_sub = 1; m_elapsed = 0; m_ph = P_CHECK;
               end else m_err = 1;
            end else m_err = 1;
         end
         P_CHECK: begin
            m_err = kv;
            if (wp) begin
               m_tries--; dq.delete(); m_pw = 0;
               if (m_tries == 0) begin m_lock = 1; m_ph = P_LOCK; end
               else m_ph = P_ENTRY;
            end else begin
               m_elapsed++;
               if (m_elapsed == CHECK_LAT) begin m_acc = 1; m_ph = P_ACC; end
            end
         end
         default: m_err = kv;
      endcase
   endtask
   task automatic cmp_model(string tag);
      chk({tag, " password_input"}, int'(password_input), m_pw);
      chk({tag, " psw_submit"}, int'(psw_submit), m_sub);
      chk({tag, " digit_count"}, int'(digit_count), dq.size());
      chk({tag, " tries_left"}, int'(tries_left), m_tries);
      chk({tag, " accepted"}, int'(accepted), m_acc);
      chk({tag, " card_locked"}, int'(card_locked), m_lock);
      chk({tag, " key_err"}, int'(key_err), m_err);
   endtask
   task automatic step(string tag, bit rs, bit ci, bit kv, logic [3:0] kc, bit wp);
      rst = rs; card_in = ci; key_valid = kv; key_code = kc; wrong_psw = wp;
      @(posedge clk);
      #1;
      model(rs, ci, kv, kc, wp);
      cmp_model(tag);
   endtask
   task automatic key(string tag, logic [3:0] kc);
      step(tag, 1'b0, 1'b1, 1'b1, kc, 1'b0);
   endtask
   task automatic idle(string tag, bit wp);
      step(tag, 1'b0, 1'b1, 1'b0, 4'h0, wp);
   endtask
   task automatic enter_pin(string tag, logic [15:0] p);
      for (int i = 3; i >= 0; i--) key(tag, p[i*4 +: 4]);
      key(tag, 4'hE);
   endtask
   task automatic add(bit rs, bit ci, bit kv, logic [3:0] kc, bit wp,
                      int pw, int sub, int cnt, int tr, int acc, int lk, int er);
      vec_t v;
      v.rs = rs; v.ci = ci; v.kv = kv; v.kc = kc; v.wp = wp;
      v.pw = pw; v.sub = sub; v.cnt = cnt; v.tries = tr; v.acc = acc; v.lock = lk; v.err = er;
      vecs.push_back(v);
   endtask
   initial begin
      //   rs ci kv kc    wp  pw       sub cnt tr acc lk err
      add(1, 0, 0, 4'h0, 0, 0,       0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 4'h0, 0, 0,       0, 0, 3, 0, 0, 0);
      add(0, 1, 1, 4'h1, 0, 0,       0, 1, 3, 0, 0, 0);
      add(0, 1, 1, 4'h2, 0, 0,       0, 2, 3, 0, 0, 0);
      add(0, 1, 1, 4'h3, 0, 0,       0, 3, 3, 0, 0, 0);
      add(0, 1, 1, 4'h4, 0, 0,       0, 4, 3, 0, 0, 0);
      add(0, 1, 1, 4'hE, 0, 'h1234,  1, 4, 3, 0, 0, 0);
      add(0, 1, 0, 4'h0, 0, 'h1234,  0, 4, 3, 0, 0, 0);
      add(0, 1, 0, 4'h0, 0, 'h1234,  0, 4, 3, 0, 0, 0);
      add(0, 1, 0, 4'h0, 0, 'h1234,  0, 4, 3, 0, 0, 0);
      add(0, 1, 0, 4'h0, 0, 'h1234,  0, 4, 3, 1, 0, 0);
      add(0, 1, 1, 4'h5, 0, 'h1234,  0, 4, 3, 1, 0, 1);
      add(0, 0, 0, 4'h0, 0, 0,       0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 4'h0, 0, 0,       0, 0, 3, 0, 0, 0);
      add(0, 1, 1, 4'h5, 0, 0,       0, 1, 3, 0, 0, 0);
      add(0, 1, 1, 4'h6, 0, 0,       0, 2, 3, 0, 0, 0);
      add(0, 1, 1, 4'h7, 0, 0,       0, 3, 3, 0, 0, 0);
      add(0, 1, 1, 4'hB, 0, 0,       0, 2, 3, 0, 0, 0);
      add(0, 1, 1, 4'h8, 0, 0,       0, 3, 3, 0, 0, 0);
      add(0, 1, 1, 4'h9, 0, 0,       0, 4, 3, 0, 0, 0);
      add(0, 1, 1, 4'h7, 0, 0,       0, 4, 3, 0, 0, 1);
      add(0, 1, 1, 4'hE, 0, 'h5689,  1, 4, 3, 0, 0, 0);
      add(0, 1, 1, 4'h3, 0, 'h5689,  0, 4, 3, 0, 0, 1);
      foreach (vecs[i]) begin
         string t = $sformatf("vec%0d", i);
         step(t, vecs[i].rs, vecs[i].ci, vecs[i].kv, vecs[i].kc, vecs[i].wp);
         chk({t, " tbl pw"}, int'(password_input), vecs[i].pw);
         chk({t, " tbl submit"}, int'(psw_submit), vecs[i].sub);
         chk({t, " tbl count"}, int'(digit_count), vecs[i].cnt);
         chk({t, " tbl tries"}, int'(tries_left), vecs[i].tries);
         chk({t, " tbl accepted"}, int'(accepted), vecs[i].acc);
         chk({t, " tbl locked"}, int'(card_locked), vecs[i].lock);
         chk({t, " tbl key_err"}, int'(key_err), vecs[i].err);
      end
      // three failures on window cycle 1 lock the session
      step("lk_out", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      idle("lk_in", 1'b0);
      for (int k = 0; k < 3; k++) begin
         enter_pin("lk_pin", 16'h4321);
         idle("lk_w0", 1'b0);
         idle("lk_w1", 1'b1);
         chk("lk tries", int'(tries_left), 2 - k);
         chk("lk count", int'(digit_count), 0);
         chk("lk locked", int'(card_locked), (k == 2) ? 1 : 0);
      end
      key("lk_key", 4'h1);
      chk("lk key_err", int'(key_err), 1);
      step("lk_out2", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      idle("lk_in2", 1'b0);
      chk("relock tries", int'(tries_left), 3);
      chk("relock locked", int'(card_locked), 0);
      // mismatch on the last window cycle is a failure
      enter_pin("last_pin", 16'h9876);
      for (int c = 0; c < CHECK_LAT - 1; c++) idle("last_w", 1'b0);
      idle("last_wl", 1'b1);
      chk("last tries", int'(tries_left), 2);
      chk("last accepted", int'(accepted), 0);
      chk("last pw", int'(password_input), 0);
      // enter short, card pulled during check, reset mid-entry
      key("short1", 4'h3);
      key("short2", 4'h7);
      key("short_e", 4'hE);
      chk("short key_err", int'(key_err), 1);
      chk("short submit", int'(psw_submit), 0);
      key("short3", 4'h0);
      key("short4", 4'h2);
      key("short_e2", 4'hE);
      chk("full submit", int'(psw_submit), 1);
      chk("full pw", int'(password_input), 'h3702);
      idle("pull_w0", 1'b0);
      step("pull", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      chk("pull pw", int'(password_input), 0);
      idle("rst_in", 1'b0);
      key("rst_k1", 4'h8);
      key("rst_k2", 4'h8);
      step("rst_mid", 1'b1, 1'b1, 1'b1, 4'h8, 1'b0);
      chk("rst count", int'(digit_count), 0);
      chk("rst tries", int'(tries_left), 0);
      chk("rst err", int'(key_err), 0);
      for (int n = 0; n < 3000; n++) begin
         int r = $urandom_range(0, 15);
         logic [3:0] kc = (r < 11) ? 4'(r) : (r < 13) ? 4'hE : (r == 13) ? 4'hB : (r == 14) ? 4'hC : 4'hF;
         step("rnd", $urandom_range(0, 511) == 0, $urandom_range(0, 63) != 0,
              $urandom_range(0, 1) == 1, kc, $urandom_range(0, 5) == 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
